capture_buffer_ctrl: RTL and testbench
======================================

# capture_buffer_ctrl

Capture controller that sits directly upstream of the 2048x9 sample block RAM (RAMB16_S9 port: CLK/ADDR/DI/DIP/DO/DOP/EN/SSR/WE) and drives all of its ports. It writes the incoming sample stream into the RAM as a circular pre-trigger buffer, marks the trigger sample, and stops after a programmable post-trigger count. It then reads the buffer back oldest-first over a valid/ready stream toward the host transmitter.

## Interface
- ADDR_W, 11: RAM address width; depth is 2^ADDR_W.
- DATA_W, 8: sample width; equals RAM DI/DO width.
- clock  in  1  sole clock; RAM CLK is tied to it.
- reset_n  in  1  asynchronous, active-low reset.
- arm  in  1  start-capture pulse; accepted only in IDLE or DONE.
- abort  in  1  return to IDLE from any state.
- delay_count  in  ADDR_W+1  post-trigger sample count; latched on accepted arm.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  DATA_W  sample.
- trigger  in  1  trigger flag; qualified by sample_valid.
- mem_addr  out  ADDR_W  RAM ADDR.
- mem_di  out  DATA_W  RAM DI.
- mem_dip  out  1  RAM DIP; 1 marks the trigger sample.
- mem_en  out  1  RAM EN.
- mem_we  out  1  RAM WE; RAM SSR is tied 0 at the parent.
- mem_do  in  DATA_W  RAM DO.
- mem_dop  in  1  RAM DOP.
- rd_valid  out  1  readout word valid.
- rd_data  out  DATA_W+1  {trigger mark, sample}.
- rd_ready  in  1  consumer accepts the word.
- busy  out  1  state is not IDLE and not DONE.
- triggered  out  1  trigger has been seen in this capture.
- done  out  1  one-cycle pulse when the last readout word is accepted.

## Operation
- States: IDLE, FILL, POST, READ, DONE.
- IDLE/DONE + arm: clear wr_ptr, fill count, triggered, and wrapped; latch delay_count; go to FILL.
- Write path, in FILL and POST: each sample_valid cycle writes {trigger&&FILL, sample_data} at wr_ptr, then wr_ptr increments mod 2^ADDR_W. On wrap, wrapped is set.
- FILL + sample_valid + trigger: the trigger sample is written with mark 1 and triggered is set. If the latched delay is 0, go to READ; otherwise go to POST with post_cnt = delay.
- POST: each sample_valid cycle writes the sample with mark 0 and decrements post_cnt. The write that takes post_cnt to 0 also moves the state to READ.
- A trigger arriving in POST is ignored. A delay larger than the depth overwrites the pre-trigger samples; this is intended behaviour.
- READ:
  - Start address is wr_ptr if wrapped, else 0.
  - Word count is 2^ADDR_W if wrapped, else wr_ptr.
  - At most one read is outstanding. The controller issues the address with mem_en=1, mem_we=0; the RAM output is captured into rd_data the next cycle and rd_valid is raised.
  - rd_data is held stable until rd_valid && rd_ready; the next address is issued on that handshake cycle.
  - When the last word is accepted: done pulses and the state goes to DONE.
- Capture-complete readout with a count of 0 (unreachable, since at least one sample is written): go straight to DONE.
- abort: go to IDLE on the next edge. Deassert mem_we/mem_en and rd_valid, and clear triggered. RAM contents are undefined afterwards.
- arm outside IDLE/DONE is ignored. abort and arm in the same cycle: abort wins.

## Timing
- Reset values:
  - State = IDLE.
  - mem_addr, mem_di, mem_dip, mem_en, mem_we = 0.
  - rd_valid, rd_data, busy, triggered, done = 0.
- All outputs are registered.
- Write latency: a sample accepted at edge N drives mem_* during cycle N+1; the RAM writes it at edge N+2.
- Readout: address is issued in cycle R; rd_valid is asserted from R+2.
- Peak throughput is one word per 2 cycles when rd_ready is held high.
- Reset asserted mid-capture or mid-readout clears everything immediately (asynchronous). The first arm is accepted on the first edge after deassertion.
- Simultaneous final POST write and the READ transition: the write is issued, and the first read address is issued no earlier than the following cycle.

## Structure
- Shared package holds:
  - the state enum;
  - DEPTH = 2**ADDR_W;
  - the rd_data bit positions (mark at DATA_W).
- No sub-module is needed. An optional sub-module, buffer_read_seq (address/count sequencer for READ), keeps the FSM readable.

## Test plan
- arm, delay_count=4, 10 samples 0x00..0x09 with trigger on 0x05 → the write stops after 0x09. Readout is 10 words 0x000..0x004, 0x105, 0x006..0x009, then done pulses.
- delay_count=0, 3000 samples of 0xAA with trigger on sample 2500 → 2048 words. The mark is on the last word, and the first word is the sample at index 453.
- delay_count=0, trigger on the first sample → exactly one word 0x1xx, then done.
- Random rd_ready throttling during readout → rd_data is stable while stalled, and there are no dropped or duplicated words.
- abort during POST, then arm → mem_we is 0 on the next cycle, triggered=0, and the new capture behaves normally.
- reset_n pulsed low for 3 cycles mid-READ → every output is 0 immediately, and the state is IDLE.

Source files
------------

// File: rtl/capture_buffer_ctrl_pkg.sv
// Shared types and helpers for the capture buffer controller.
// Holds the controller state set, buffer depth and readout word layout.
package capture_buffer_ctrl_pkg;

    localparam int CBC_ADDR_W = 11;
    localparam int CBC_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_POST,
        ST_READ,
        ST_DONE
    } cap_state_t;

    // Buffer depth for a given address width.
    function automatic int buf_depth(input int aw);
        return 2 ** aw;
    endfunction

    // Bit position of the trigger mark inside a readout word.
    function automatic int mark_pos(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/capture_buffer_ctrl.sv
// Circular pre-trigger capture into a 2^ADDR_W x (DATA_W+1) block RAM with
// post-trigger countdown, followed by oldest-first valid/ready readout.
module capture_buffer_ctrl
    import capture_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W = CBC_ADDR_W,
    parameter int DATA_W = CBC_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W:0]   delay_count,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              trigger,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    output logic              mem_dip,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_do,
    input  logic              mem_dop,
    output logic              rd_valid,
    output logic [DATA_W:0]   rd_data,
    input  logic              rd_ready,
    output logic              busy,
    output logic              triggered,
    output logic              done
);

    localparam int              MARK       = mark_pos(DATA_W);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(buf_depth(ADDR_W));
    localparam logic [ADDR_W:0] ONE_CNT    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

    cap_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic                wrapped_reg, wrapped_next;
    logic [ADDR_W:0]     delay_reg, delay_next;
    logic [ADDR_W:0]     post_cnt_reg, post_cnt_next;
    logic                triggered_reg, triggered_next;
    logic                rd_init_reg, rd_init_next;
    logic [ADDR_W:0]     rd_left_reg, rd_left_next;
    logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
    logic                issue_reg, issue_next;
    logic                dout_full_reg, dout_full_next;
    logic                rd_valid_reg, rd_valid_next;
    logic [DATA_W:0]     rd_data_reg, rd_data_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_di_reg, mem_di_next;
    logic                mem_dip_reg, mem_dip_next;
    logic                mem_en_reg, mem_en_next;
    logic                mem_we_reg, mem_we_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                wr_fire, rd_hs, rd_move, rd_issue;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            wrapped_reg   <= 1'b0;
            delay_reg     <= '0;
            post_cnt_reg  <= '0;
            triggered_reg <= 1'b0;
            rd_init_reg   <= 1'b0;
            rd_left_reg   <= '0;
            rd_addr_reg   <= '0;
            issue_reg     <= 1'b0;
            dout_full_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_data_reg   <= '0;
            mem_addr_reg  <= '0;
            mem_di_reg    <= '0;
            mem_dip_reg   <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            wrapped_reg   <= wrapped_next;
            delay_reg     <= delay_next;
            post_cnt_reg  <= post_cnt_next;
            triggered_reg <= triggered_next;
            rd_init_reg   <= rd_init_next;
            rd_left_reg   <= rd_left_next;
            rd_addr_reg   <= rd_addr_next;
            issue_reg     <= issue_next;
            dout_full_reg <= dout_full_next;
            rd_valid_reg  <= rd_valid_next;
            rd_data_reg   <= rd_data_next;
            mem_addr_reg  <= mem_addr_next;
            mem_di_reg    <= mem_di_next;
            mem_dip_reg   <= mem_dip_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        wrapped_next   = wrapped_reg;
        delay_next     = delay_reg;
        post_cnt_next  = post_cnt_reg;
        triggered_next = triggered_reg;
        rd_init_next   = 1'b0;
        rd_left_next   = rd_left_reg;
        rd_addr_next   = rd_addr_reg;
        issue_next     = 1'b0;
        dout_full_next = dout_full_reg;
        rd_valid_next  = rd_valid_reg;
        rd_data_next   = rd_data_reg;
        mem_addr_next  = mem_addr_reg;
        mem_di_next    = mem_di_reg;
        mem_dip_next   = mem_dip_reg;
        mem_en_next    = 1'b0;
        mem_we_next    = 1'b0;
        done_next      = 1'b0;
        busy_next      = 1'b0;
        rd_move        = 1'b0;
        rd_issue       = 1'b0;
        wr_fire        = sample_valid && (state_reg == ST_FILL || state_reg == ST_POST);
        rd_hs          = rd_valid_reg && rd_ready;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_next     = ST_FILL;
                    wr_ptr_next    = '0;
                    wrapped_next   = 1'b0;
                    triggered_next = 1'b0;
                    delay_next     = delay_count;
                end
            end
            ST_FILL: begin
                if (sample_valid && trigger) begin
                    triggered_next = 1'b1;
                    if (delay_reg == '0) begin
                        state_next   = ST_READ;
                        rd_init_next = 1'b1;
                    end else begin
                        state_next    = ST_POST;
                        post_cnt_next = delay_reg;
                    end
                end
            end
            ST_POST: begin
                if (sample_valid) begin
                    post_cnt_next = post_cnt_reg - ONE_CNT;
                    if (post_cnt_reg == ONE_CNT) begin
                        state_next   = ST_READ;
                        rd_init_next = 1'b1;
                    end
                end
            end
            ST_READ: begin
                // First READ cycle only loads the sequencer, so the final
                // capture write is never overlapped by a read address.
                if (rd_init_reg) begin
                    rd_left_next = wrapped_reg ? FULL_COUNT : {1'b0, wr_ptr_reg};
                    rd_addr_next = wrapped_reg ? wr_ptr_reg : '0;
                end else begin
                    // RAM DO acts as a one-word prefetch stage behind rd_data.
                    rd_move  = dout_full_reg && (!rd_valid_reg || rd_hs);
                    rd_issue = (rd_left_reg != '0) && !issue_reg
                               && (!dout_full_reg || rd_move);
                    dout_full_next = issue_reg || (dout_full_reg && !rd_move);
                    if (rd_move) begin
                        rd_valid_next              = 1'b1;
                        rd_data_next[MARK]         = mem_dop;
                        rd_data_next[MARK-1:0]     = mem_do;
                    end else if (rd_hs) begin
                        rd_valid_next = 1'b0;
                    end
                    if (rd_issue) begin
                        mem_addr_next = rd_addr_reg;
                        mem_en_next   = 1'b1;
                        issue_next    = 1'b1;
                        rd_addr_next  = rd_addr_reg + ONE_ADDR;
                        rd_left_next  = rd_left_reg - ONE_CNT;
                    end
                    if (rd_left_reg == '0 && !issue_reg && !dout_full_reg
                        && (rd_hs || !rd_valid_reg)) begin
                        state_next = ST_DONE;
                        done_next  = rd_hs;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (wr_fire) begin
            mem_addr_next = wr_ptr_reg;
            mem_di_next   = sample_data;
            mem_dip_next  = trigger && (state_reg == ST_FILL);
            mem_en_next   = 1'b1;
            mem_we_next   = 1'b1;
            wr_ptr_next   = wr_ptr_reg + ONE_ADDR;
            if (wr_ptr_reg == '1) begin
                wrapped_next = 1'b1;
            end
        end

        if (abort) begin
            state_next     = ST_IDLE;
            mem_en_next    = 1'b0;
            mem_we_next    = 1'b0;
            rd_valid_next  = 1'b0;
            triggered_next = 1'b0;
            done_next      = 1'b0;
            issue_next     = 1'b0;
            dout_full_next = 1'b0;
            rd_init_next   = 1'b0;
        end

        busy_next = (state_next == ST_FILL) || (state_next == ST_POST)
                    || (state_next == ST_READ);
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_di    = mem_di_reg;
    assign mem_dip   = mem_dip_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign busy      = busy_reg;
    assign triggered = triggered_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Bench for capture_buffer_ctrl: behavioural RAM, stream-level reference model
// (readout = newest min(N, depth) written words, oldest first).
module tb_capture_buffer_ctrl;
    import capture_buffer_ctrl_pkg::*;

    localparam int AW    = CBC_ADDR_W;
    localparam int DW    = CBC_DATA_W;
    localparam int DEPTH = 2048;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   delay_count = '0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          trigger = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic          mem_dip;
    logic          mem_en;
    logic          mem_we;
    logic [DW-1:0] mem_do;
    logic          mem_dop;
    logic          rd_valid;
    logic [DW:0]   rd_data;
    logic          rd_ready = 1'b0;
    logic          busy;
    logic          triggered;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] wr_q[$];

    always #5 clock = ~clock;

    capture_buffer_ctrl dut (
        .clock(clock), .reset_n(reset_n), .arm(arm), .abort(abort),
        .delay_count(delay_count), .sample_valid(sample_valid),
        .sample_data(sample_data), .trigger(trigger),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_dip(mem_dip),
        .mem_en(mem_en), .mem_we(mem_we), .mem_do(mem_do), .mem_dop(mem_dop),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .busy(busy), .triggered(triggered), .done(done)
    );

    // 2048x9 block RAM, write-first, output held while EN is low
    logic [8:0] ram [DEPTH];
    logic [8:0] ram_q = '0;
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= {mem_dip, mem_di};
                ram_q         <= {mem_dip, mem_di};
            end else begin
                ram_q <= ram[mem_addr];
            end
        end
    end
    assign mem_do  = ram_q[7:0];
    assign mem_dop = ram_q[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one capture and records what the controller should have written.
    task automatic do_capture(input int delay, input int nsamp, input int trig_at,
                              input int mode, input bit gaps, input int abort_at);
        logic [7:0] d;
        bit trg;
        int phase;
        int post;
        wr_q.delete();
        phase = 0;
        post  = 0;
        @(posedge clock); #1;
        arm = 1'b1;
        delay_count = delay[AW:0];
        @(posedge clock); #1;
        arm = 1'b0;
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_trig_clr", 32'(triggered), 32'd0);
        for (int i = 0; i < nsamp; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                sample_valid = 1'b0;
                trigger      = 1'($urandom_range(0, 1));
                sample_data  = 8'($urandom);
                @(posedge clock); #1;
            end
            if (mode == 0)      d = i[7:0];
            else if (mode == 1) d = 8'hAA;
            else                d = 8'($urandom);
            trg = (i == trig_at) || (mode == 2 && i > trig_at && $urandom_range(0, 3) == 0);
            sample_valid = 1'b1;
            sample_data  = d;
            trigger      = trg;
            if (i == abort_at) abort = 1'b1;
            if (phase == 0) begin
                wr_q.push_back({trg, d});
                if (trg) begin
                    post  = delay;
                    phase = (delay == 0) ? 2 : 1;
                end
            end else if (phase == 1) begin
                wr_q.push_back({1'b0, d});
                post--;
                if (post == 0) phase = 2;
            end
            @(posedge clock); #1;
            if (i == abort_at) begin
                abort = 1'b0;
                sample_valid = 1'b0;
                trigger = 1'b0;
                check("abort_we", 32'(mem_we), 32'd0);
                check("abort_en", 32'(mem_en), 32'd0);
                check("abort_trig", 32'(triggered), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_rdv", 32'(rd_valid), 32'd0);
                $display("capture delay=%0d aborted at sample %0d", delay, i);
                return;
            end
            if (i == 0 && !gaps) begin
                check("wr0_we", 32'(mem_we), 32'd1);
                check("wr0_addr", 32'(mem_addr), 32'd0);
                check("wr0_di", 32'(mem_di), 32'(d));
            end
        end
        sample_valid = 1'b0;
        trigger = 1'b0;
        check("cap_triggered", 32'(triggered), 32'd1);
        $display("capture delay=%0d samples=%0d trig_at=%0d written=%0d", delay, nsamp, trig_at, wr_q.size());
    endtask

    // Drains up to max_words (all when negative) and checks order, stability and done.
    task automatic readout(input bit throttle, input int max_words);
        int nexp, start, lim, got, budget;
        logic [8:0] held;
        bit have_held;
        nexp  = (wr_q.size() > DEPTH) ? DEPTH : wr_q.size();
        start = wr_q.size() - nexp;
        lim   = (max_words >= 0 && max_words < nexp) ? max_words : nexp;
        got = 0;
        budget = 8 * nexp + 50;
        have_held = 1'b0;
        held = '0;
        while (got < lim && budget > 0) begin
            @(posedge clock); #1;
            rd_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clock);
            budget--;
            if (have_held) check("stall_hold", 32'({rd_valid, rd_data}), 32'({1'b1, held}));
            have_held = 1'b0;
            if (rd_valid) begin
                if (rd_ready) begin
                    check($sformatf("word%0d", got), 32'(rd_data), 32'(wr_q[start + got]));
                    got++;
                end else begin
                    held = rd_data;
                    have_held = 1'b1;
                end
            end
        end
        check("word_count", 32'(got), 32'(lim));
        if (lim == nexp) begin
            @(negedge clock);
            check("done_pulse", 32'(done), 32'd1);
            check("done_busy", 32'(busy), 32'd0);
            check("done_rdv", 32'(rd_valid), 32'd0);
            @(negedge clock);
            check("done_clear", 32'(done), 32'd0);
            check("no_extra", 32'(rd_valid), 32'd0);
        end
        rd_ready = 1'b0;
        $display("readout words=%0d of %0d throttle=%0d", got, nexp, throttle);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_di"}, 32'({mem_dip, mem_di}), 32'd0);
        check({tag, "_en_we"}, 32'({mem_en, mem_we}), 32'd0);
        check({tag, "_rdv"}, 32'(rd_valid), 32'd0);
        check({tag, "_rdd"}, 32'(rd_data), 32'd0);
        check({tag, "_flags"}, 32'({busy, triggered, done}), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Spec example: 10 samples, trigger on 0x05, delay 4, extras ignored
        do_capture(4, 12, 5, 0, 1'b0, -1);
        readout(1'b0, -1);

        // Wrapped buffer: 2501 words written, newest 2048 returned
        do_capture(0, 3000, 2500, 0, 1'b0, -1);
        readout(1'b0, -1);

        // Trigger on the very first sample with zero delay
        do_capture(0, 5, 0, 2, 1'b0, -1);
        readout(1'b0, -1);

        // Delay larger than depth overwrites the trigger mark
        do_capture(2100, 2110, 5, 2, 1'b0, -1);
        readout(1'b0, -1);

        // Random captures with gaps and throttled readout
        for (int k = 0; k < 3; k++) begin
            do_capture(int'($urandom_range(1, 30)), 80, int'($urandom_range(0, 40)), 2, 1'b1, -1);
            readout(1'b1, -1);
        end

        // Abort during POST, then a normal capture
        do_capture(50, 30, 3, 2, 1'b0, 10);
        do_capture(3, 20, 7, 2, 1'b1, -1);
        readout(1'b1, -1);

        // Asynchronous reset mid-readout
        do_capture(8, 40, 20, 2, 1'b1, -1);
        readout(1'b1, 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(posedge clock);
        #1;
        check("rst_idle_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        arm = 1'b1;
        delay_count = 12'd8;
        @(posedge clock); #1;
        arm = 1'b0;
        check("rst_first_arm", 32'(busy), 32'd1);
        do_capture(8, 40, 20, 2, 1'b1, -1);
        readout(1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
